ext_align_pipe: RTL and testbench

- Parametrised, pipelined load-data aligner and immediate extender for the datapath; sits between the MDR/instruction register and the ALU/register-file write mux.
- Selects a byte, halfword or word lane by address offset, sign- or zero-extends it, or extends/shifts an instruction immediate.
- Two register stages with valid/ready back-pressure, misalignment detection and a saturating error counter.

---
 rtl/ext_align_pipe.sv | 157 +++++++++++++++
 tb/tb_ext_align_pipe.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_align_pipe.sv
// Load-data lane aligner and immediate extender. Two register stages, so a result
// appears 2 cycles after accept. Stage 2 holds while the consumer stalls; in_ready drops only when both stages are full.
module ext_align_pipe #(
  parameter  int DATA_W    = 32,
  parameter  int IMM_W     = 16,
  parameter  int ERR_CNT_W = 8,
  localparam int OFF_W     = $clog2(DATA_W / 8)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           mode,
  input  logic [OFF_W-1:0]     byte_off,
  input  logic [DATA_W-1:0]    data_in,
  input  logic [IMM_W-1:0]     imm_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    data_out,
  output logic                 misalign,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [2:0] {
    MODE_LB       = 3'b000,
    MODE_LBU      = 3'b001,
    MODE_LH       = 3'b010,
    MODE_LHU      = 3'b011,
    MODE_LW       = 3'b100,
    MODE_IMM_SEXT = 3'b101,
    MODE_IMM_ZEXT = 3'b110,
    MODE_IMM_LUI  = 3'b111
  } mode_e;

  // Stage 1: raw lane, zero-padded to DATA_W, plus its mode and misalign flag
  logic                 s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0]    s1_lane_q,  s1_lane_d;
  mode_e                s1_mode_q,  s1_mode_d;
  logic                 s1_mis_q,   s1_mis_d;

  // Stage 2: the visible outputs
  logic                 out_valid_q, out_valid_d;
  logic [DATA_W-1:0]    data_out_q,  data_out_d;
  logic                 misalign_q,  misalign_d;
  logic [ERR_CNT_W-1:0] err_cnt_q,   err_cnt_d;

  logic                 s2_adv;
  logic                 s1_free;
  logic [7:0]           byte_sel;
  logic [15:0]          half_sel;
  logic [DATA_W-1:0]    lane_sel;
  logic                 lane_mis;
  logic [DATA_W-1:0]    ext_res;
  logic                 err_inc;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_free  = !s1_valid_q || s2_adv;
  assign in_ready = !flush && s1_free;

  assign byte_sel = 8'(data_in >> {byte_off, 3'b000});
  assign half_sel = 16'(data_in >> {byte_off[OFF_W-1:1], 4'b0000});

  always_comb begin
    lane_sel = '0;
    lane_mis = 1'b0;
    unique case (mode)
      MODE_LB, MODE_LBU: lane_sel = DATA_W'(byte_sel);
      MODE_LH, MODE_LHU: begin
        if (byte_off[0]) lane_mis = 1'b1;
        else             lane_sel = DATA_W'(half_sel);
      end
      MODE_LW: begin
        if (|byte_off) lane_mis = 1'b1;
        else           lane_sel = data_in;
      end
      default: lane_sel = DATA_W'(imm_in);
    endcase
  end

  always_comb begin
    ext_res = s1_lane_q;
    unique case (s1_mode_q)
      MODE_LB:       ext_res = {{(DATA_W-8){s1_lane_q[7]}}, s1_lane_q[7:0]};
      MODE_LH:       ext_res = {{(DATA_W-16){s1_lane_q[15]}}, s1_lane_q[15:0]};
      MODE_IMM_SEXT: ext_res = {{(DATA_W-IMM_W){s1_lane_q[IMM_W-1]}}, s1_lane_q[IMM_W-1:0]};
      MODE_IMM_LUI:  ext_res = {s1_lane_q[IMM_W-1:0], {(DATA_W-IMM_W){1'b0}}};
      default:       ext_res = s1_lane_q;
    endcase
    if (s1_mis_q) ext_res = '0;
  end

  // A result killed by flush in the same cycle never counts as delivered
  assign err_inc = out_valid_q && out_ready && misalign_q && !flush;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_lane_d   = s1_lane_q;
    s1_mode_d   = s1_mode_q;
    s1_mis_d    = s1_mis_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    misalign_d  = misalign_q;
    err_cnt_d   = err_cnt_q;

    if (flush) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (s1_free) begin
        s1_valid_d = in_valid;
        if (in_valid) begin
          s1_lane_d = lane_sel;
          s1_mode_d = mode_e'(mode);
          s1_mis_d  = lane_mis;
        end
      end
      if (s2_adv) begin
        out_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          data_out_d = ext_res;
          misalign_d = s1_mis_q;
        end
      end
    end

    if (err_inc && !(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_lane_q   <= '0;
      s1_mode_q   <= MODE_LB;
      s1_mis_q    <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      misalign_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_lane_q   <= s1_lane_d;
      s1_mode_q   <= s1_mode_d;
      s1_mis_q    <= s1_mis_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      misalign_q  <= misalign_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign misalign  = misalign_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_ext_align_pipe.sv
// Bench for ext_align_pipe: a 32-bit instance driven through all scenarios and a
// 64-bit instance for the wide-datapath lane and misalign rules.
module tb_ext_align_pipe;
  localparam int DW = 32;
  localparam int IW = 16;
  localparam int EW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, flush, in_valid, in_ready, out_valid, out_ready, misalign;
  logic [2:0]    mode;
  logic [1:0]    byte_off;
  logic [DW-1:0] data_in, data_out;
  logic [IW-1:0] imm_in;
  logic [EW-1:0] err_count;

  logic          w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_misalign;
  logic [2:0]    w_mode;
  logic [2:0]    w_byte_off;
  logic [63:0]   w_data_in, w_data_out;
  logic [IW-1:0] w_imm_in;
  logic [EW-1:0] w_err_count;

  ext_align_pipe #(.DATA_W(DW), .IMM_W(IW), .ERR_CNT_W(EW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .byte_off(byte_off), .data_in(data_in), .imm_in(imm_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .misalign(misalign), .err_count(err_count)
  );

  ext_align_pipe #(.DATA_W(64), .IMM_W(IW), .ERR_CNT_W(EW)) dut_w (
    .clk(clk), .reset_n(reset_n), .flush(w_flush), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .mode(w_mode), .byte_off(w_byte_off), .data_in(w_data_in), .imm_in(w_imm_in),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .data_out(w_data_out),
    .misalign(w_misalign), .err_count(w_err_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [64:0] exp_q[$];
  int          exp_err;
  logic        c_acc, c_dlv, c_ov, c_mis, c_under;
  logic [DW-1:0] c_dat;
  logic [64:0] c_exp;

  // Reference: {misalign, value} from the load/immediate rules, for a dw-bit datapath
  function automatic logic [64:0] ref_ext(input int dw, input logic [2:0] m, input int off,
                                          input logic [63:0] d, input logic [15:0] imm);
    logic [63:0] v, mask;
    logic        mis;
    mis  = 1'b0;
    v    = '0;
    mask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'h1 << dw) - 64'h1);
    case (m)
      3'd0, 3'd1: begin
        v = (d >> (8 * off)) & 64'hFF;
        if (m == 3'd0 && v[7]) v = v | ~64'hFF;
      end
      3'd2, 3'd3: begin
        mis = (off % 2) != 0;
        v   = (d >> (16 * (off / 2))) & 64'hFFFF;
        if (m == 3'd2 && v[15]) v = v | ~64'hFFFF;
      end
      3'd4: begin
        mis = off != 0;
        v   = d;
      end
      3'd5: begin
        v = {48'h0, imm};
        if (imm[15]) v = v | ~64'hFFFF;
      end
      3'd6:    v = {48'h0, imm};
      default: v = {48'h0, imm} << (dw - 16);
    endcase
    if (mis) v = '0;
    return {mis, v & mask};
  endfunction

  // One clock: observe handshakes at the falling edge, maintain the scoreboard
  task automatic cycle();
    @(negedge clk);
    c_acc   = in_valid && in_ready;
    c_dlv   = out_valid && out_ready;
    c_ov    = out_valid;
    c_dat   = data_out;
    c_mis   = misalign;
    c_under = 1'b0;
    c_exp   = '0;
    if (c_dlv && !flush) begin
      if (exp_q.size() == 0) c_under = 1'b1;
      else begin
        c_exp = exp_q.pop_front();
        if (c_exp[64] && exp_err < 255) exp_err++;
      end
    end
    if (flush) exp_q.delete();
    if (c_acc) exp_q.push_back(ref_ext(DW, mode, int'(byte_off), {32'h0, data_in}, imm_in));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (data_out !== 32'h0) begin n_bad++; $display("FAIL reset_data_out: got %h want 0", data_out); end
    n_cmp++; if (misalign !== 1'b0) begin n_bad++; $display("FAIL reset_misalign: got %b want 0", misalign); end
    n_cmp++; if (err_count !== 8'h0) begin n_bad++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  m;
    logic [1:0]  off;
    logic [31:0] d;
    logic [15:0] imm;
    logic [31:0] x;
    logic        mis;
  } vec_t;

  task automatic test_directed();
    vec_t vt[8];
    int   lat;
    logic got;
    vt[0] = '{3'd0, 2'd2, 32'h1285_3456, 16'h0, 32'hFFFF_FF85, 1'b0};
    vt[1] = '{3'd1, 2'd2, 32'h1285_3456, 16'h0, 32'h0000_0085, 1'b0};
    vt[2] = '{3'd2, 2'd2, 32'h8001_7FFF, 16'h0, 32'hFFFF_8001, 1'b0};
    vt[3] = '{3'd3, 2'd0, 32'h8001_7FFF, 16'h0, 32'h0000_7FFF, 1'b0};
    vt[4] = '{3'd2, 2'd1, 32'h8001_7FFF, 16'h0, 32'h0000_0000, 1'b1};
    vt[5] = '{3'd5, 2'd3, 32'hDEAD_BEEF, 16'hF000, 32'hFFFF_F000, 1'b0};
    vt[6] = '{3'd6, 2'd1, 32'hDEAD_BEEF, 16'hF000, 32'h0000_F000, 1'b0};
    vt[7] = '{3'd7, 2'd2, 32'hDEAD_BEEF, 16'h1234, 32'h1234_0000, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mode = vt[i].m; byte_off = vt[i].off; data_in = vt[i].d; imm_in = vt[i].imm;
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      n_cmp++; if (c_acc !== 1'b1) begin n_bad++; $display("FAIL dir%0d_accept: got %b want 1", i, c_acc); end
      lat = 0;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
        cycle();
        lat++;
        if (c_dlv) got = 1'b1;
      end
      n_cmp++; if (!got || lat != 2) begin n_bad++; $display("FAIL dir%0d_latency: got %0d (seen %b) want 2", i, lat, got); end
      n_cmp++; if (c_dat !== vt[i].x) begin n_bad++; $display("FAIL dir%0d_data: got %h want %h", i, c_dat, vt[i].x); end
      n_cmp++; if (c_mis !== vt[i].mis) begin n_bad++; $display("FAIL dir%0d_misalign: got %b want %b", i, c_mis, vt[i].mis); end
    end
    n_cmp++; if (err_count !== 8'd1) begin n_bad++; $display("FAIL dir_err_count: got %0d want 1", err_count); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      mode      = 3'($urandom_range(0, 7));
      byte_off  = 2'($urandom);
      data_in   = $urandom;
      imm_in    = 16'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      cycle();
      if (c_dlv) begin
        n_cmp++;
        if (c_under || c_dat !== c_exp[31:0] || c_mis !== c_exp[64]) begin
          n_bad++;
          $display("FAIL rand%0d: got %h/%b want %h/%b (empty %b)", i, c_dat, c_mis, c_exp[31:0], c_exp[64], c_under);
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin
      cycle();
      if (c_dlv) begin
        n_cmp++;
        if (c_under || c_dat !== c_exp[31:0] || c_mis !== c_exp[64]) begin
          n_bad++;
          $display("FAIL rand_drain: got %h/%b want %h/%b", c_dat, c_mis, c_exp[31:0], c_exp[64]);
        end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rand_lost: got %0d pending want 0", exp_q.size()); end
    n_cmp++; if (err_count !== 8'(exp_err)) begin n_bad++; $display("FAIL rand_err_count: got %0d want %0d", err_count, exp_err); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] bp[4];
    logic [31:0] hold;
    logic        seen;
    int          acc, dl, cyc, stab_bad;
    for (int i = 0; i < 4; i++) bp[i] = $urandom | 32'h1;
    out_ready = 1'b0;
    mode = 3'd4; byte_off = 2'd0; data_in = bp[0]; in_valid = 1'b1;
    acc = 0; seen = 1'b0; hold = '0; stab_bad = 0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      if (c_acc) begin acc++; if (acc < 4) data_in = bp[acc]; end
      if (seen && (c_ov !== 1'b1 || c_dat !== hold)) stab_bad++;
      if (!seen && c_ov) begin seen = 1'b1; hold = c_dat; end
    end
    n_cmp++; if (acc != 2) begin n_bad++; $display("FAIL bp_accepts: got %0d want 2", acc); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (!seen || stab_bad != 0) begin n_bad++; $display("FAIL bp_stable: got %0d changes (seen %b) want 0", stab_bad, seen); end
    n_cmp++; if (hold !== bp[0]) begin n_bad++; $display("FAIL bp_head: got %h want %h", hold, bp[0]); end
    out_ready = 1'b1;
    dl = 0; cyc = 0;
    while (dl < 4 && cyc < 20) begin
      cycle();
      cyc++;
      if (c_acc) begin
        acc++;
        if (acc < 4) data_in = bp[acc];
        else in_valid = 1'b0;
      end
      if (c_dlv) begin
        n_cmp++;
        if (c_dat !== bp[dl] || c_mis !== 1'b0) begin
          n_bad++;
          $display("FAIL bp_order%0d: got %h/%b want %h/0", dl, c_dat, c_mis, bp[dl]);
        end
        dl++;
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (dl != 4 || cyc != 4) begin n_bad++; $display("FAIL bp_throughput: got %0d results in %0d cycles want 4 in 4", dl, cyc); end
  endtask

  task automatic test_flush();
    int          acc;
    logic [31:0] dat_before;
    out_ready = 1'b0;
    mode = 3'd4; byte_off = 2'd1; data_in = $urandom; in_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 8 && acc < 2; c++) begin
      cycle();
      if (c_acc) acc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || acc != 2) begin n_bad++; $display("FAIL flush_fill: got out_valid %b accepts %0d want 1 and 2", out_valid, acc); end
    dat_before = data_out;
    flush = 1'b1;
    in_valid = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    n_cmp++; if (c_acc !== 1'b0) begin n_bad++; $display("FAIL flush_accept: got %b want 0", c_acc); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (misalign !== 1'b1 || data_out !== dat_before) begin n_bad++; $display("FAIL flush_stale: got %h/%b want %h/1", data_out, misalign, dat_before); end
    n_cmp++; if (err_count !== 8'(exp_err)) begin n_bad++; $display("FAIL flush_err_count: got %0d want %0d", err_count, exp_err); end
    out_ready = 1'b1;
    acc = 0;
    repeat (3) begin
      cycle();
      if (c_ov) acc++;
    end
    n_cmp++; if (acc != 0) begin n_bad++; $display("FAIL flush_ghost: got %0d results want 0", acc); end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    in_valid = 1'b1;
    mode = 3'd4;
    byte_off = 2'd2;
    for (int i = 0; i < 300; i++) begin
      data_in = $urandom;
      cycle();
    end
    in_valid = 1'b0;
    repeat (4) cycle();
    n_cmp++; if (err_count !== 8'd255) begin n_bad++; $display("FAIL sat_err_count: got %0d want 255", err_count); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL sat_lost: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_async_reset();
    int ov_cnt;
    out_ready = 1'b1;
    in_valid = 1'b1;
    mode = 3'd4;
    byte_off = 2'd0;
    data_in = $urandom | 32'h8000_0000;
    repeat (3) cycle();
    n_cmp++; if (out_valid !== 1'b1 || err_count !== 8'd255) begin n_bad++; $display("FAIL arst_pre: got out_valid %b err %0d want 1 and 255", out_valid, err_count); end
    #3;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (data_out !== 32'h0 || misalign !== 1'b0) begin n_bad++; $display("FAIL arst_data: got %h/%b want 0/0", data_out, misalign); end
    n_cmp++; if (err_count !== 8'h0) begin n_bad++; $display("FAIL arst_err_count: got %0d want 0", err_count); end
    in_valid = 1'b0;
    exp_q.delete();
    exp_err = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    ov_cnt = 0;
    repeat (3) begin
      cycle();
      if (c_ov) ov_cnt++;
    end
    n_cmp++; if (ov_cnt != 0) begin n_bad++; $display("FAIL arst_partial: got %0d results want 0", ov_cnt); end
  endtask

  task automatic test_wide();
    logic [2:0]  wm[3];
    logic [2:0]  wo[3];
    logic [63:0] wd[3];
    logic [63:0] wx[3];
    logic        wmis[3];
    logic [64:0] r;
    logic        got, acc;
    logic [63:0] gd;
    logic        gm;
    wm[0] = 3'd4; wo[0] = 3'd4; wd[0] = 64'h0123_4567_89AB_CDEF; wx[0] = 64'h0;                   wmis[0] = 1'b1;
    wm[1] = 3'd2; wo[1] = 3'd6; wd[1] = 64'h8123_4567_89AB_CDEF; wx[1] = 64'hFFFF_FFFF_FFFF_8123; wmis[1] = 1'b0;
    wm[2] = 3'd3; wo[2] = 3'd6; wd[2] = 64'h8123_4567_89AB_CDEF; wx[2] = 64'h0000_0000_0000_8123; wmis[2] = 1'b0;
    w_out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i < 3) begin
        w_mode = wm[i]; w_byte_off = wo[i]; w_data_in = wd[i]; w_imm_in = 16'h0;
      end else begin
        w_mode = 3'($urandom_range(0, 7)); w_byte_off = 3'($urandom);
        w_data_in = {$urandom, $urandom}; w_imm_in = 16'($urandom);
      end
      r = ref_ext(64, w_mode, int'(w_byte_off), w_data_in, w_imm_in);
      w_in_valid = 1'b1;
      @(negedge clk);
      acc = w_in_valid && w_in_ready;
      @(posedge clk);
      #1;
      w_in_valid = 1'b0;
      got = 1'b0; gd = '0; gm = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        @(negedge clk);
        if (w_out_valid) begin got = 1'b1; gd = w_data_out; gm = w_misalign; end
        @(posedge clk);
        #1;
      end
      n_cmp++; if (!acc || !got) begin n_bad++; $display("FAIL wide%0d_handshake: got accept %b result %b want 1 1", i, acc, got); end
      if (i < 3) begin
        n_cmp++; if (gd !== wx[i] || gm !== wmis[i]) begin n_bad++; $display("FAIL wide%0d: got %h/%b want %h/%b", i, gd, gm, wx[i], wmis[i]); end
      end else begin
        n_cmp++; if (gd !== r[63:0] || gm !== r[64]) begin n_bad++; $display("FAIL wide%0d: got %h/%b want %h/%b", i, gd, gm, r[63:0], r[64]); end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mode = '0; byte_off = '0; data_in = '0; imm_in = '0;
    w_flush = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b0;
    w_mode = '0; w_byte_off = '0; w_data_in = '0; w_imm_in = '0;
    exp_err = 0;
    c_acc = 1'b0; c_dlv = 1'b0; c_ov = 1'b0; c_mis = 1'b0; c_under = 1'b0; c_dat = '0; c_exp = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_saturation();
    test_async_reset();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
